keypad_decoder: RTL and testbench

- Downstream consumer of the 4x3 keypad monitor's pad-side signals: takes column lines and the rows as read back from the pads.
- Synchronises and debounces them, then decodes a single pressed key into a 4-bit code.
- Delivers one press event per key press over a valid/ready handshake to the system side.
- Flags multi-key (ghosting) patterns and dropped events.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 keypad decoder: geometry, FSM encoding
// and the row/column to key-code mapping.
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 3;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_e;

    function automatic logic [KEY_CODE_W-1:0] rc_to_code(
        input logic [1:0] row_idx,
        input logic [1:0] col_idx
    );
        logic [KEY_CODE_W-1:0] row_w;
        logic [KEY_CODE_W-1:0] col_w;
        row_w = {2'b00, row_idx};
        col_w = {2'b00, col_idx};
        return (row_w * KEY_CODE_W'(NUM_COLS)) + col_w;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous pad lines, with synchronous
// active-high reset clearing both stages.
module keypad_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter: capture the pad value, then re-register it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_decoder.sv
// Keypad decoder: synchronises the pad lines, debounces a single key press and
// release, and hands one code per press to the system over valid/ready.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_COLS-1:0]   COL,
    input  logic [NUM_ROWS-1:0]   ROW_READ,
    output logic [KEY_CODE_W-1:0] KEY_CODE,
    output logic                  KEY_VALID,
    input  logic                  KEY_READY,
    output logic                  ERROR,
    output logic                  OVERRUN,
    input  logic                  OVERRUN_CLR
);

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_COLS-1:0]   s_col_s;
    logic [NUM_ROWS-1:0]   s_row_s;
    logic [1:0]            row_idx_s;
    logic [1:0]            col_idx_s;
    logic                  row_one_s;
    logic                  col_one_s;
    logic                  pat_single_s;
    logic                  pat_none_s;
    logic                  pat_other_s;
    logic                  match_s;
    logic [KEY_CODE_W-1:0] code_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  cnt_done_s;

    kp_state_e             state_r;
    kp_state_e             state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [KEY_CODE_W-1:0] cand_r;
    logic [KEY_CODE_W-1:0] cand_nxt_s;
    logic                  issue_s;

    logic [KEY_CODE_W-1:0] key_code_r;
    logic                  key_valid_r;
    logic                  error_r;
    logic                  overrun_r;
    logic                  xfer_s;
    logic                  overrun_set_s;

    keypad_sync #(.WIDTH(NUM_COLS)) u_sync_col (
        .clk (CLK),
        .rst (RST),
        .d   (COL),
        .q   (s_col_s)
    );

    keypad_sync #(.WIDTH(NUM_ROWS)) u_sync_row (
        .clk (CLK),
        .rst (RST),
        .d   (ROW_READ),
        .q   (s_row_s)
    );

    // One-hot row decode; anything not exactly one row high is not single.
    always_comb begin
        row_idx_s = 2'd0;
        row_one_s = 1'b0;
        case (s_row_s)
            4'b0001: begin row_idx_s = 2'd0; row_one_s = 1'b1; end
            4'b0010: begin row_idx_s = 2'd1; row_one_s = 1'b1; end
            4'b0100: begin row_idx_s = 2'd2; row_one_s = 1'b1; end
            4'b1000: begin row_idx_s = 2'd3; row_one_s = 1'b1; end
            default: begin row_idx_s = 2'd0; row_one_s = 1'b0; end
        endcase
    end

    // One-hot column decode.
    always_comb begin
        col_idx_s = 2'd0;
        col_one_s = 1'b0;
        case (s_col_s)
            3'b001:  begin col_idx_s = 2'd0; col_one_s = 1'b1; end
            3'b010:  begin col_idx_s = 2'd1; col_one_s = 1'b1; end
            3'b100:  begin col_idx_s = 2'd2; col_one_s = 1'b1; end
            default: begin col_idx_s = 2'd0; col_one_s = 1'b0; end
        endcase
    end

    assign pat_single_s = row_one_s & col_one_s;
    assign pat_none_s   = ~(|s_row_s) & ~(|s_col_s);
    assign pat_other_s  = ~pat_single_s & ~pat_none_s;
    assign code_s       = rc_to_code(row_idx_s, col_idx_s);
    assign match_s      = pat_single_s & (code_s == cand_r);

    // Saturating increment so the count can never wrap past the limit.
    assign cnt_inc_s  = (cnt_r == DB_LIMIT) ? cnt_r : (cnt_r + CNT_ONE);
    assign cnt_done_s = (cnt_inc_s == DB_LIMIT);

    // Debounce FSM state, count and candidate key registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            cand_r  <= {KEY_CODE_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cand_r  <= cand_nxt_s;
        end
    end

    // Debounce next-state logic; a different key while held counts as release.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cand_nxt_s  = cand_r;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pat_single_s) begin
                    cand_nxt_s  = code_s;
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = ST_PRESS_DB;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS_DB: begin
                if (match_s) begin
                    cnt_nxt_s = cnt_inc_s;
                    if (cnt_done_s) begin
                        state_nxt_s = ST_HELD;
                        issue_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_PRESS_DB;
                    end
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (match_s) begin
                    state_nxt_s = ST_HELD;
                end else begin
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (match_s) begin
                    state_nxt_s = ST_HELD;
                end else if (cnt_done_s) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                    state_nxt_s = ST_RELEASE_DB;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign xfer_s        = key_valid_r & KEY_READY;
    assign overrun_set_s = issue_s & key_valid_r & ~xfer_s;

    // Output event register: load on issue when the slot is free or draining.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_code_r  <= {KEY_CODE_W{1'b0}};
            key_valid_r <= 1'b0;
        end else if (issue_s && (!key_valid_r || xfer_s)) begin
            key_code_r  <= cand_r;
            key_valid_r <= 1'b1;
        end else if (xfer_s) begin
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= key_valid_r;
        end
    end

    // Ghosting flag and sticky overrun flag; a set beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            error_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            error_r <= pat_other_s;
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (OVERRUN_CLR) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign KEY_CODE  = key_code_r;
    assign KEY_VALID = key_valid_r;
    assign ERROR     = error_r;
    assign OVERRUN   = overrun_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed self-checking bench for keypad_decoder with a 4-cycle debounce.
module tb_keypad_decoder;

    logic       clk_s = 1'b0;
    logic       rst_s = 1'b1;
    logic [2:0] col_s = 3'b000;
    logic [3:0] row_s = 4'b0000;
    logic [3:0] key_code_s;
    logic       key_valid_s;
    logic       key_ready_s = 1'b1;
    logic       error_s;
    logic       overrun_s;
    logic       overrun_clr_s = 1'b0;

    int check_count = 0;
    int error_count = 0;
    int xfer_count  = 0;
    int last_xfer_code = 0;

    keypad_decoder #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .CLK         (clk_s),
        .RST         (rst_s),
        .COL         (col_s),
        .ROW_READ    (row_s),
        .KEY_CODE    (key_code_s),
        .KEY_VALID   (key_valid_s),
        .KEY_READY   (key_ready_s),
        .ERROR       (error_s),
        .OVERRUN     (overrun_s),
        .OVERRUN_CLR (overrun_clr_s)
    );

    always #5 clk_s = ~clk_s;

    // Count completed handshakes and remember the last transferred code.
    always @(posedge clk_s) begin
        if (key_valid_s && key_ready_s) begin
            xfer_count     <= xfer_count + 1;
            last_xfer_code <= int'(key_code_s);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        check_count++;
        if (obs != exp) begin
            error_count++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_s);
            #1;
        end
    endtask

    task automatic set_pins(input logic [3:0] r, input logic [2:0] c);
        row_s = r;
        col_s = c;
    endtask

    initial begin
        int base;
        int first;
        int nvalid;
        int code_seen;

        // Reset state
        tick(2);
        rst_s = 1'b0;
        check_eq("rst_valid", key_valid_s, 0);
        check_eq("rst_code", key_code_s, 0);
        check_eq("rst_error", error_s, 0);
        check_eq("rst_overrun", overrun_s, 0);

        // Clean press of key 7, held 20 cycles
        base = xfer_count;
        first = -1;
        nvalid = 0;
        code_seen = -1;
        set_pins(4'b0100, 3'b010);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (key_valid_s) begin
                nvalid++;
                if (first < 0) begin
                    first = i;
                    code_seen = int'(key_code_s);
                end
            end
        end
        check_eq("clean_latency", first, 6);
        check_eq("clean_pulses", nvalid, 1);
        check_eq("clean_code", code_seen, 7);
        check_eq("clean_xfers", xfer_count - base, 1);
        set_pins(4'b0000, 3'b000);
        tick(10);

        // Bounce: 3 on / 1 off, four times, then stable
        base = xfer_count;
        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            set_pins(4'b0001, 3'b001);
            for (int j = 0; j < 3; j++) begin
                tick(1);
                if (key_valid_s) nvalid++;
            end
            set_pins(4'b0000, 3'b000);
            tick(1);
            if (key_valid_s) nvalid++;
        end
        check_eq("bounce_quiet", nvalid, 0);
        set_pins(4'b0001, 3'b001);
        tick(12);
        check_eq("bounce_xfers", xfer_count - base, 1);
        check_eq("bounce_code", last_xfer_code, 0);
        set_pins(4'b0000, 3'b000);
        tick(10);

        // Ghosting: two rows high, then drop to one
        base = xfer_count;
        set_pins(4'b0011, 3'b001);
        tick(2);
        check_eq("ghost_err_c2", error_s, 0);
        tick(1);
        check_eq("ghost_err_c3", error_s, 1);
        tick(5);
        check_eq("ghost_no_evt", xfer_count - base, 0);
        set_pins(4'b0001, 3'b001);
        tick(2);
        check_eq("ghost_err_hold", error_s, 1);
        tick(1);
        check_eq("ghost_err_clr", error_s, 0);
        tick(7);
        check_eq("ghost_xfers", xfer_count - base, 1);
        check_eq("ghost_code", last_xfer_code, 0);
        set_pins(4'b0000, 3'b000);
        tick(10);

        // Backpressure: code 11 pending, code 4 dropped, set beats clear
        key_ready_s = 1'b0;
        set_pins(4'b1000, 3'b100);
        tick(8);
        check_eq("bp_valid", key_valid_s, 1);
        check_eq("bp_code", key_code_s, 11);
        set_pins(4'b0000, 3'b000);
        tick(8);
        overrun_clr_s = 1'b1;
        set_pins(4'b0010, 3'b010);
        tick(6);
        overrun_clr_s = 1'b0;
        check_eq("bp_ovr_set_wins", overrun_s, 1);
        check_eq("bp_code_kept", key_code_s, 11);
        tick(2);
        base = xfer_count;
        key_ready_s = 1'b1;
        tick(1);
        check_eq("bp_valid_drop", key_valid_s, 0);
        check_eq("bp_xfer_cnt", xfer_count - base, 1);
        check_eq("bp_xfer_code", last_xfer_code, 11);
        check_eq("bp_ovr_sticky", overrun_s, 1);
        overrun_clr_s = 1'b1;
        tick(1);
        overrun_clr_s = 1'b0;
        check_eq("bp_ovr_clr", overrun_s, 0);
        set_pins(4'b0000, 3'b000);
        tick(8);

        // Issue coinciding with a transfer: new code loads, no overrun
        key_ready_s = 1'b0;
        set_pins(4'b1000, 3'b100);
        tick(8);
        set_pins(4'b0000, 3'b000);
        tick(8);
        set_pins(4'b0010, 3'b010);
        tick(5);
        key_ready_s = 1'b1;
        tick(1);
        check_eq("same_valid", key_valid_s, 1);
        check_eq("same_code", key_code_s, 4);
        check_eq("same_no_ovr", overrun_s, 0);
        tick(1);
        check_eq("same_drain", key_valid_s, 0);
        check_eq("same_xfer_code", last_xfer_code, 4);
        set_pins(4'b0000, 3'b000);
        tick(8);

        // Short release does not re-arm; a full release does
        base = xfer_count;
        set_pins(4'b0010, 3'b100);
        tick(8);
        set_pins(4'b0000, 3'b000);
        tick(2);
        set_pins(4'b0010, 3'b100);
        tick(8);
        check_eq("short_rel_one", xfer_count - base, 1);
        set_pins(4'b0000, 3'b000);
        tick(4);
        set_pins(4'b0010, 3'b100);
        tick(8);
        check_eq("full_rel_two", xfer_count - base, 2);
        check_eq("full_rel_code", last_xfer_code, 5);
        set_pins(4'b0000, 3'b000);
        tick(8);

        // Reset during press debounce, then a fresh event from the held key
        key_ready_s = 1'b0;
        set_pins(4'b0100, 3'b010);
        tick(4);
        rst_s = 1'b1;
        tick(1);
        rst_s = 1'b0;
        check_eq("rst_pdb_valid", key_valid_s, 0);
        check_eq("rst_pdb_error", error_s, 0);
        tick(5);
        check_eq("rst_pdb_early", key_valid_s, 0);
        tick(1);
        check_eq("rst_pdb_evt", key_valid_s, 1);
        check_eq("rst_pdb_code", key_code_s, 7);

        // Reset with an event pending, overrun and error set
        set_pins(4'b0000, 3'b000);
        tick(8);
        set_pins(4'b0001, 3'b001);
        tick(8);
        check_eq("rst_pre_ovr", overrun_s, 1);
        set_pins(4'b0011, 3'b001);
        tick(4);
        check_eq("rst_pre_err", error_s, 1);
        rst_s = 1'b1;
        tick(1);
        rst_s = 1'b0;
        check_eq("rst_pend_valid", key_valid_s, 0);
        check_eq("rst_pend_error", error_s, 0);
        check_eq("rst_pend_ovr", overrun_s, 0);
        check_eq("rst_pend_code", key_code_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
